// File: rtl/mc_moving_average.sv
// -----------------------------------------------------------------------------
// mc_moving_average
//
// Time-multiplexed moving-average filter. Each of CHANNELS channels keeps its
// own WINDOW_LENGTH-deep sample history, a running sum, a write pointer and a
// fill counter. Each accepted sample updates its channel's sum incrementally
// (add the new sample, subtract the one it overwrites). One cycle later the
// window mean is presented.
//
// Optional feature macro: MA_ROUNDING_EN
//   defined   : filter_out = (sum + WINDOW_LENGTH/2) >>> log2(WINDOW_LENGTH)
//   undefined : filter_out =  sum >>> log2(WINDOW_LENGTH)            (floor)
//
// Parameters
//   CHANNELS       number of multiplexed channels (1..64)
//   WINDOW_LENGTH  samples per window, power of two (2..256)
//   DATA_WIDTH     two's-complement sample width
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   flush        one-cycle request to clear every channel history
//   in_valid     sample strobe
//   in_ready     high while samples are accepted (RUN state)
//   in_channel   channel index of the sample
//   data_in      signed sample
//   out_valid    result strobe, one cycle after acceptance
//   out_channel  channel of the result
//   filter_out   signed windowed mean
//   out_primed   the result's window was fully populated
//   err_channel  one-cycle pulse after an out-of-range sample was dropped
// -----------------------------------------------------------------------------
module mc_moving_average #(
  parameter int CHANNELS      = 8,
  parameter int WINDOW_LENGTH = 16,
  parameter int DATA_WIDTH    = 16,
  localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CH_W-1:0]              in_channel,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         out_valid,
  output logic [CH_W-1:0]              out_channel,
  output logic signed [DATA_WIDTH-1:0] filter_out,
  output logic                         out_primed,
  output logic                         err_channel
);

  localparam int LOG2W = $clog2(WINDOW_LENGTH);
  localparam int SUM_W = DATA_WIDTH + LOG2W;
  localparam int CNT_W = LOG2W + 1;

  localparam logic [CH_W:0]            CH_LIM   = (CH_W + 1)'(CHANNELS);
  localparam logic [CNT_W-1:0]         FILL_MAX = CNT_W'(WINDOW_LENGTH);
  localparam logic [LOG2W-1:0]         IDX_LAST = LOG2W'(WINDOW_LENGTH - 1);
  localparam logic signed [SUM_W-1:0]  HALF     = SUM_W'(WINDOW_LENGTH / 2);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  // Sign-extend a sample to running-sum width.
  function automatic logic signed [SUM_W-1:0] sext(input logic signed [DATA_WIDTH-1:0] v);
    return {{LOG2W{v[DATA_WIDTH-1]}}, v};
  endfunction

  // Divide the window sum by WINDOW_LENGTH. The sum range guarantees the
  // quotient fits DATA_WIDTH, and adding HALF cannot overflow SUM_W.
  function automatic logic signed [DATA_WIDTH-1:0] mean_of(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] t;
`ifdef MA_ROUNDING_EN
    t = s + HALF;
`else
    t = s;
`endif
    t = t >>> LOG2W;
    return t[DATA_WIDTH-1:0];
  endfunction

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [LOG2W-1:0]             r_clr_idx;

  logic signed [DATA_WIDTH-1:0] r_hist [CHANNELS][WINDOW_LENGTH];
  logic signed [SUM_W-1:0]      r_sum  [CHANNELS];
  logic [LOG2W-1:0]             r_ptr  [CHANNELS];
  logic [CNT_W-1:0]             r_fill [CHANNELS];

  logic                         w_in_range;
  logic                         w_accept;
  logic                         w_drop;
  logic [CH_W-1:0]              w_ch;
  logic signed [DATA_WIDTH-1:0] w_oldest;
  logic signed [SUM_W-1:0]      w_sum_nxt;
  logic [CNT_W-1:0]             w_fill_nxt;
  logic                         w_primed;

  logic                         r_vld_p1;
  logic                         r_err_p1;
  logic [CH_W-1:0]              r_ch_p1;
  logic signed [DATA_WIDTH-1:0] r_mean_p1;
  logic                         r_primed_p1;

  // FSM state register and clear-address counter. A flush in either state
  // (re)starts the clear sweep at address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR && !flush) begin
        r_clr_idx <= r_clr_idx + 1'b1;
      end else begin
        r_clr_idx <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        if (!flush && r_clr_idx == IDX_LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        in_ready = 1'b1;
        if (flush) w_state_nxt = S_CLEAR;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Stage p0: channel lookup and incremental sum update.
  assign w_in_range = ({1'b0, in_channel} < CH_LIM);
  // A sample arriving with flush is discarded along with the histories.
  assign w_accept   = in_valid && in_ready && !flush && w_in_range;
  assign w_drop     = in_valid && in_ready && !w_in_range;
  // Clamp so the array lookups below never index past the last channel.
  assign w_ch       = w_in_range ? in_channel : '0;
  assign w_oldest   = r_hist[w_ch][r_ptr[w_ch]];
  assign w_sum_nxt  = r_sum[w_ch] + sext(data_in) - sext(w_oldest);
  assign w_fill_nxt = (r_fill[w_ch] == FILL_MAX) ? r_fill[w_ch] : r_fill[w_ch] + 1'b1;
  assign w_primed   = (w_fill_nxt == FILL_MAX);

  // Unfilled history reads back as zero, so the partial-window mean needs no
  // special case. Sums, pointers and counters clear on the first clear cycle.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_hist[c][r_clr_idx] <= '0;
        if (r_clr_idx == '0) begin
          r_sum[c]  <= '0;
          r_ptr[c]  <= '0;
          r_fill[c] <= '0;
        end
      end
    end else if (w_accept) begin
      r_hist[w_ch][r_ptr[w_ch]] <= data_in;
      r_sum[w_ch]               <= w_sum_nxt;
      r_ptr[w_ch]               <= r_ptr[w_ch] + 1'b1;
      r_fill[w_ch]              <= w_fill_nxt;
    end
  end

  // Stage p1: registered result; data fields hold while no result is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1    <= 1'b0;
      r_err_p1    <= 1'b0;
      r_ch_p1     <= '0;
      r_mean_p1   <= '0;
      r_primed_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_accept;
      r_err_p1 <= w_drop;
      if (w_accept) begin
        r_ch_p1     <= w_ch;
        r_mean_p1   <= mean_of(w_sum_nxt);
        r_primed_p1 <= w_primed;
      end
    end
  end

  assign out_valid   = r_vld_p1;
  assign err_channel = r_err_p1;
  assign out_channel = r_ch_p1;
  assign filter_out  = r_mean_p1;
  assign out_primed  = r_primed_p1;

endmodule
